fir_uart_word_tx: RTL and testbench
===================================

Name: fir_uart_word_tx

Overview:
- Parametrised successor to the FIR-result UART transmit controller.
- Accepts DATA_W-bit FIR results through a valid/ready handshake and buffers them in a small FIFO.
- Each result is serialised into NUM_BYTES bytes, in a selectable byte order, optionally preceded by a sync header byte, and driven into the existing byte-wide UART transmitter (TxD_start/TxD_busy).
- Sits between the FIR filter output and the UART TX core.

Parameters:
- DATA_W, 16: result width in bits, 1..32. NUM_BYTES = ceil(DATA_W/8) is derived, not set.
- FIFO_DEPTH, 4: input buffer entries; power of two, 2..16.
- MSB_FIRST, 0: 0 = least significant byte first, 1 = most significant byte first.
- HEADER_EN, 0: 1 = send the HEADER byte before each word.
- HEADER, 8'hA5: sync byte value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- FIR_valid  in  1  result present on FIR_data.
- FIR_data  in  DATA_W  FIR result.
- FIR_ready  out  1  FIFO not full.
- TxD_busy  in  1  UART transmitter busy.
- TxD_start  out  1  one-cycle start pulse to the UART.
- TxD_data  out  8  byte to transmit; stable from the TxD_start cycle until busy falls.
- overflow  out  1  sticky: FIR_valid was seen while FIR_ready was 0.
- tx_active  out  1  high whenever the FSM is not in IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of FIFO entries.

Behaviour:
- Reset (rst=0 at a clock edge):
  - FSM goes to IDLE; FIFO is emptied.
  - TxD_start=0, TxD_data=0, overflow=0, tx_active=0, fifo_level=0, FIR_ready=1.
  - Reset mid-frame abandons the frame. No further start pulses are issued.
- FIFO:
  - A write occurs when FIR_valid && FIR_ready.
  - A read (pop) occurs in the LOAD state.
  - FIR_ready = (level != FIFO_DEPTH). It is registered from level, so it does not depend combinationally on the pop.
  - A simultaneous write and pop leaves level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A write attempt while full is dropped and sets overflow (cleared only by reset).
- Shift register:
  - In LOAD, the FIFO head is zero-extended to NUM_BYTES*8 bits into shreg.
  - The byte counter is set to NUM_BYTES-1.
- State machine:
  - IDLE: go to LOAD if the FIFO is non-empty.
  - LOAD: pop the FIFO and load shreg. Go to HDR_START if HEADER_EN, else to BYTE_START.
  - HDR_START: TxD_data=HEADER, TxD_start=1; go to HDR_ARM.
  - HDR_ARM: TxD_start=0, TxD_busy ignored; go to HDR_WAIT.
  - HDR_WAIT: stay while TxD_busy=1; on TxD_busy=0 go to BYTE_START.
  - BYTE_START: TxD_start=1.
    - TxD_data = shreg[7:0] if MSB_FIRST=0, else shreg[NUM_BYTES*8-1 -: 8].
    - Go to BYTE_ARM.
  - BYTE_ARM: TxD_busy ignored. Shift shreg by 8 toward the next byte and decrement the counter; go to BYTE_WAIT.
  - BYTE_WAIT: stay while TxD_busy=1. On TxD_busy=0:
    - counter wrapped past zero → IDLE, or directly LOAD if the FIFO is non-empty (back-to-back words, no idle cycle);
    - otherwise → BYTE_START.
- Timing and registration:
  - TxD_start and TxD_data are registered outputs. The start pulse is exactly 1 cycle wide.
  - Latency from a FIFO write into an empty, idle block to TxD_start: 3 cycles (write, IDLE→LOAD, LOAD→START registered).
- Edge cases:
  - TxD_busy already high during a *_START state does not delay the pulse; the UART owns collision handling.
  - DATA_W=8 gives NUM_BYTES=1: a single byte per word. The counter must not underflow into extra bytes.
- FIFO contents are not altered by TxD activity other than the pop in LOAD.

Test Plan:
1. Reset with rst=0 for 2 cycles while FIR_valid=1 → all outputs 0, FIR_ready=1, no writes captured. Then rst=1 with DATA_W=16, MSB_FIRST=0, FIR_data=16'h1234, one valid cycle → TxD_start pulses with TxD_data 8'h34 then 8'h12, one pulse per busy-low. tx_active returns to 0.
2. MSB_FIRST=1, HEADER_EN=1, DATA_W=24, word 24'hABCDEF → byte sequence A5, AB, CD, EF. Exactly 4 single-cycle start pulses, each issued only after TxD_busy falls.
3. DATA_W=12, word 12'hFFF, LSB first → bytes FF, 0F (zero-extended upper byte).
4. FIFO_DEPTH=4, UART held busy, 6 consecutive valid words:
   - FIR_ready drops once level=4;
   - overflow=1 after the first dropped word;
   - after release, the 5 accepted words (1 in flight + 4 buffered) are sent in order with no IDLE gap between words.
5. rst=0 asserted while BYTE_WAIT holds the second byte of a word → next cycle state IDLE, fifo_level=0, no further TxD_start even after TxD_busy falls.
6. DATA_W=8, words 8'h01, 8'h02 back-to-back → exactly 2 start pulses, data 01 then 02; the counter does not generate a third byte.

Source files
------------

// File: rtl/fir_uart_word_tx_if.sv
// Handshake bundle between the FIR result source, this serialiser and the byte-wide UART core.
interface fir_uart_word_tx_if #(
  parameter int DATA_W = 16
);
  logic              FIR_valid;
  logic [DATA_W-1:0] FIR_data;
  logic              FIR_ready;
  logic              TxD_busy;
  logic              TxD_start;
  logic [7:0]        TxD_data;

  modport master (
    output FIR_valid, FIR_data, TxD_busy,
    input  FIR_ready, TxD_start, TxD_data
  );

  modport slave (
    input  FIR_valid, FIR_data, TxD_busy,
    output FIR_ready, TxD_start, TxD_data
  );
endinterface

// File: rtl/fir_uart_word_tx.sv
// Buffers FIR results in a small FIFO and serialises each into bytes (optional sync header)
// for a byte-wide UART transmitter with a start/busy handshake.
module fir_uart_word_tx #(
  parameter int         DATA_W     = 16,
  parameter int         FIFO_DEPTH = 4,
  parameter bit         MSB_FIRST  = 1'b0,
  parameter bit         HEADER_EN  = 1'b0,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst,
  fir_uart_word_tx_if.slave           bus,
  output logic                        overflow,
  output logic                        tx_active,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int NUM_BYTES = (DATA_W + 7) / 8;
  localparam int SW        = NUM_BYTES * 8;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int LW        = AW + 1;
  localparam int CW        = 3;

  typedef enum logic [2:0] {
    IDLE, LOAD, HDR_START, HDR_ARM, HDR_WAIT, BYTE_START, BYTE_ARM, BYTE_WAIT
  } state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wrPtr_q, rdPtr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              ready_q, overflow_q;
  logic              wrEn, popEn;

  state_t            state_q, state_d;
  logic [SW-1:0]     shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              start_q, start_d;
  logic [7:0]        data_q, data_d;

  assign wrEn  = bus.FIR_valid && ready_q;
  assign popEn = (state_q == LOAD);

  always_comb begin
    level_d = level_q + LW'(wrEn) - LW'(popEn);
  end

  // Ready is registered from the next level so it never depends combinationally on the pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (wrEn) begin
        mem_q[wrPtr_q] <= bus.FIR_data;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (popEn) rdPtr_q <= rdPtr_q + 1'b1;
      level_q <= level_d;
      ready_q <= (level_d != LW'(FIFO_DEPTH));
      if (bus.FIR_valid && !ready_q) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      data_q  <= data_d;
    end
  end

  // The counter runs NUM_BYTES-1 down past zero; its top bit marks the last byte as done.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE:       if (level_q != '0) state_d = LOAD;
      LOAD: begin
        shreg_d = SW'(mem_q[rdPtr_q]);
        cnt_d   = CW'(NUM_BYTES - 1);
        state_d = HEADER_EN ? HDR_START : BYTE_START;
      end
      HDR_START:  state_d = HDR_ARM;
      HDR_ARM:    state_d = HDR_WAIT;
      HDR_WAIT:   if (!bus.TxD_busy) state_d = BYTE_START;
      BYTE_START: state_d = BYTE_ARM;
      BYTE_ARM: begin
        shreg_d = MSB_FIRST ? (shreg_q << 8) : (shreg_q >> 8);
        cnt_d   = cnt_q - 1'b1;
        state_d = BYTE_WAIT;
      end
      BYTE_WAIT: begin
        if (!bus.TxD_busy) begin
          if (cnt_q[CW-1]) state_d = (level_q != '0) ? LOAD : IDLE;
          else             state_d = BYTE_START;
        end
      end
      default:    state_d = IDLE;
    endcase

    // Start and data are registered together with the state so the pulse lines up with *_START.
    if (state_d == HDR_START) begin
      start_d = 1'b1;
      data_d  = HEADER;
    end else if (state_d == BYTE_START) begin
      start_d = 1'b1;
      data_d  = MSB_FIRST ? shreg_d[SW-1 -: 8] : shreg_d[7:0];
    end
  end

  assign bus.FIR_ready = ready_q;
  assign bus.TxD_start = start_q;
  assign bus.TxD_data  = data_q;
  assign overflow      = overflow_q;
  assign tx_active     = (state_q != IDLE);
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_fir_uart_word_tx.sv
// Self-checking bench: four parameterisations of fir_uart_word_tx driven by directed word vectors
// against a simple UART busy model that logs every start pulse.
module tb_fir_uart_word_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  logic        vldDrv  = 1'b0;
  logic [31:0] dataDrv = '0;
  logic [1:0]  sel     = 2'd0;
  logic        hold    = 1'b0;
  logic [3:0]  busyR   = '0;

  fir_uart_word_tx_if #(.DATA_W(16)) if16 ();
  fir_uart_word_tx_if #(.DATA_W(24)) if24 ();
  fir_uart_word_tx_if #(.DATA_W(12)) if12 ();
  fir_uart_word_tx_if #(.DATA_W(8))  if8 ();

  logic       ovf16, ovf24, ovf12, ovf8;
  logic       act16, act24, act12, act8;
  logic [2:0] lvl16, lvl24, lvl12, lvl8;

  fir_uart_word_tx #(.DATA_W(16), .FIFO_DEPTH(4), .MSB_FIRST(1'b0), .HEADER_EN(1'b0), .HEADER(8'hA5)) u16 (
    .clk(clk), .rst(rst), .bus(if16), .overflow(ovf16), .tx_active(act16), .fifo_level(lvl16));
  fir_uart_word_tx #(.DATA_W(24), .FIFO_DEPTH(4), .MSB_FIRST(1'b1), .HEADER_EN(1'b1), .HEADER(8'hA5)) u24 (
    .clk(clk), .rst(rst), .bus(if24), .overflow(ovf24), .tx_active(act24), .fifo_level(lvl24));
  fir_uart_word_tx #(.DATA_W(12), .FIFO_DEPTH(4), .MSB_FIRST(1'b0), .HEADER_EN(1'b0), .HEADER(8'hA5)) u12 (
    .clk(clk), .rst(rst), .bus(if12), .overflow(ovf12), .tx_active(act12), .fifo_level(lvl12));
  fir_uart_word_tx #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b0), .HEADER_EN(1'b0), .HEADER(8'hA5)) u8 (
    .clk(clk), .rst(rst), .bus(if8), .overflow(ovf8), .tx_active(act8), .fifo_level(lvl8));

  assign if16.FIR_valid = vldDrv && (sel == 2'd0);
  assign if24.FIR_valid = vldDrv && (sel == 2'd1);
  assign if12.FIR_valid = vldDrv && (sel == 2'd2);
  assign if8.FIR_valid  = vldDrv && (sel == 2'd3);
  assign if16.FIR_data  = dataDrv[15:0];
  assign if24.FIR_data  = dataDrv[23:0];
  assign if12.FIR_data  = dataDrv[11:0];
  assign if8.FIR_data   = dataDrv[7:0];
  assign if16.TxD_busy  = busyR[0];
  assign if24.TxD_busy  = busyR[1];
  assign if12.TxD_busy  = busyR[2];
  assign if8.TxD_busy   = busyR[3];

  logic [3:0] startV, activeV;
  logic [7:0] dataV [4];
  assign startV   = {if8.TxD_start, if12.TxD_start, if24.TxD_start, if16.TxD_start};
  assign activeV  = {act8, act12, act24, act16};
  assign dataV[0] = if16.TxD_data;
  assign dataV[1] = if24.TxD_data;
  assign dataV[2] = if12.TxD_data;
  assign dataV[3] = if8.TxD_data;

  // UART model: each start pulse is logged as {dut, byte} and makes the UART busy for a while.
  logic [9:0] capQ [$];
  logic [3:0] prevStart = '0;
  logic [7:0] lastData [4];
  int         busyCnt  [4];

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst) lastData[k] = dataV[k];
      if (startV[k]) begin
        nChecks++;
        if (prevStart[k] || busyR[k]) begin
          nErrors++;
          $display("[TB] FAIL start_protocol dut%0d: prevStart=%0b busy=%0b at start, required 0 and 0",
                   k, prevStart[k], busyR[k]);
        end
        capQ.push_back({2'(k), dataV[k]});
        lastData[k] = dataV[k];
        busyR[k]    = 1'b1;
        busyCnt[k]  = 4;
      end else if (busyR[k]) begin
        if (rst) begin
          nChecks++;
          if (dataV[k] !== lastData[k]) begin
            nErrors++;
            $display("[TB] FAIL data_stable dut%0d: TxD_data=%02h while busy, required %02h",
                     k, dataV[k], lastData[k]);
          end
        end
        if (busyCnt[k] > 0) busyCnt[k]--;
        else if (!hold) busyR[k] = 1'b0;
      end
      prevStart[k] = startV[k];
    end
  end

  typedef struct packed {
    logic [1:0]       dut;
    logic [3:0]       nw;
    logic [1:0][31:0] words;
    logic [3:0]       nb;
    logic [7:0][7:0]  bytes;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input logic [1:0] d, input logic [3:0] nw,
                              input logic [31:0] w0, input logic [31:0] w1, input logic [3:0] nb,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                              input logic [7:0] b6, input logic [7:0] b7);
    vec_t v;
    v.dut = d;  v.nw = nw;  v.words[0] = w0;  v.words[1] = w1;  v.nb = nb;
    v.bytes[0] = b0;  v.bytes[1] = b1;  v.bytes[2] = b2;  v.bytes[3] = b3;
    v.bytes[4] = b4;  v.bytes[5] = b5;  v.bytes[6] = b6;  v.bytes[7] = b7;
    return v;
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    capQ.delete();
    for (int i = 0; i < int'(v.nw); i++) begin
      @(negedge clk);
      sel     = v.dut;
      dataDrv = v.words[i];
      vldDrv  = 1'b1;
    end
    @(negedge clk);
    vldDrv = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    int cyc = 0;
    while ((capQ.size() < int'(v.nb) || activeV[v.dut]) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checkEq({tag, "_timeout"}, 32'(cyc >= 3000), 32'd0);
    repeat (30) @(negedge clk);
    checkEq({tag, "_count"}, 32'(capQ.size()), 32'(v.nb));
    for (int i = 0; i < int'(v.nb) && i < capQ.size(); i++)
      checkEq($sformatf("%s_byte%0d", tag, i), 32'(capQ[i]), 32'({v.dut, v.bytes[i]}));
    checkEq({tag, "_active"}, 32'(activeV[v.dut]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] w4 [6];
    int cyc;
    logic gap;

    vecs[0] = mk(2'd0, 4'd1, 32'h1234,   32'h0,      4'd2, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[1] = mk(2'd1, 4'd1, 32'hABCDEF, 32'h0,      4'd4, 8'hA5, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[2] = mk(2'd2, 4'd1, 32'hFFF,    32'h0,      4'd2, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[3] = mk(2'd3, 4'd2, 32'h01,     32'h02,     4'd2, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[4] = mk(2'd0, 4'd2, 32'hBEEF,   32'h0001,   4'd4, 8'hEF, 8'hBE, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[5] = mk(2'd1, 4'd2, 32'h123456, 32'h00FF00, 4'd8, 8'hA5, 8'h12, 8'h34, 8'h56, 8'hA5, 8'h00, 8'hFF, 8'h00);
    vecs[6] = mk(2'd2, 4'd2, 32'h0A5,    32'hF00,    4'd4, 8'hA5, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset held with valid asserted: nothing may be captured.
    rst = 1'b0;  sel = 2'd0;  dataDrv = 32'h1234;  vldDrv = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkEq("rst_start", 32'(if16.TxD_start), 32'd0);
    checkEq("rst_data",  32'(if16.TxD_data),  32'd0);
    checkEq("rst_ovf",   32'(ovf16),          32'd0);
    checkEq("rst_active",32'(act16),          32'd0);
    checkEq("rst_level", 32'(lvl16),          32'd0);
    checkEq("rst_ready", 32'(if16.FIR_ready), 32'd1);
    @(negedge clk);
    vldDrv = 1'b0;  rst = 1'b1;
    @(posedge clk);
    #1;
    checkEq("post_rst_level", 32'(lvl16), 32'd0);

    // First word: start appears on the second edge after the write edge.
    capQ.delete();
    @(negedge clk);
    dataDrv = 32'h1234;  vldDrv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vldDrv = 1'b0;
    @(posedge clk);
    #1;
    checkEq("lat_start_early", 32'(if16.TxD_start), 32'd0);
    @(posedge clk);
    #1;
    checkEq("lat_start", 32'(if16.TxD_start), 32'd1);
    checkEq("lat_data",  32'(if16.TxD_data),  32'h34);
    checkOutput(vecs[0], "t1");

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // UART held busy while six words arrive; the sixth must be dropped.
    w4 = '{32'h0102, 32'h0304, 32'h0506, 32'h0708, 32'h090A, 32'h0B0C};
    capQ.delete();
    hold = 1'b1;  sel = 2'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dataDrv = w4[i];  vldDrv = 1'b1;
      @(posedge clk);
      #1;
      if (i == 4) begin
        checkEq("full_ready", 32'(if16.FIR_ready), 32'd0);
        checkEq("full_level", 32'(lvl16),          32'd4);
        checkEq("full_ovf",   32'(ovf16),          32'd0);
      end
      if (i == 5) begin
        checkEq("drop_ovf",   32'(ovf16), 32'd1);
        checkEq("drop_level", 32'(lvl16), 32'd4);
      end
    end
    @(negedge clk);
    vldDrv = 1'b0;
    repeat (10) @(negedge clk);
    checkEq("held_count", 32'(capQ.size()), 32'd1);
    hold = 1'b0;
    cyc = 0;  gap = 1'b0;
    while ((capQ.size() < 10 || act16) && cyc < 3000) begin
      @(negedge clk);
      if (!act16 && capQ.size() < 10) gap = 1'b1;
      cyc++;
    end
    checkEq("burst_timeout", 32'(cyc >= 3000), 32'd0);
    checkEq("burst_gap",     32'(gap),         32'd0);
    repeat (30) @(negedge clk);
    checkEq("burst_count", 32'(capQ.size()), 32'd10);
    for (int i = 0; i < 10 && i < capQ.size(); i++)
      checkEq($sformatf("burst_byte%0d", i), 32'(capQ[i]),
              32'({2'd0, ((i % 2) == 0) ? w4[i/2][7:0] : w4[i/2][15:8]}));
    checkEq("burst_ovf_sticky", 32'(ovf16), 32'd1);

    // Reset while the last byte of a word is pending and another word waits in the FIFO.
    capQ.delete();
    @(negedge clk);
    dataDrv = 32'hA1B2;  vldDrv = 1'b1;
    @(negedge clk);
    dataDrv = 32'hC3D4;
    @(negedge clk);
    vldDrv = 1'b0;
    cyc = 0;
    while (capQ.size() < 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    hold = 1'b1;
    checkEq("midrst_timeout", 32'(cyc >= 500), 32'd0);
    repeat (3) @(negedge clk);
    checkEq("midrst_active_before", 32'(act16), 32'd1);
    checkEq("midrst_level_before",  32'(lvl16), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkEq("midrst_active", 32'(act16),          32'd0);
    checkEq("midrst_level",  32'(lvl16),          32'd0);
    checkEq("midrst_ovf",    32'(ovf16),          32'd0);
    checkEq("midrst_data",   32'(if16.TxD_data),  32'd0);
    checkEq("midrst_ready",  32'(if16.FIR_ready), 32'd1);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    hold = 1'b0;
    repeat (40) @(negedge clk);
    checkEq("midrst_count", 32'(capQ.size()), 32'd2);
    if (capQ.size() >= 2) begin
      checkEq("midrst_byte0", 32'(capQ[0]), 32'({2'd0, 8'hB2}));
      checkEq("midrst_byte1", 32'(capQ[1]), 32'({2'd0, 8'hA1}));
    end
    checkEq("midrst_idle", 32'(act16), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
